// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C poll scheduler.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_ID_REQ,
      ST_ID_WAIT,
      ST_WAIT_PERIOD,
      ST_T_REQ,
      ST_T_WAIT,
      ST_RETRY,
      ST_FAULT
   } state_t;

   // Default device and register addresses
   localparam logic [6:0] DEF_DEV_ADDR = 7'h4B;
   localparam logic [7:0] DEF_ID_REG   = 8'h0B;
   localparam logic [7:0] DEF_TEMP_REG = 8'h00;
   localparam logic [7:0] DEF_EXP_ID   = 8'hCB;

   // txn_len encoding: number of bytes to read
   localparam logic [1:0] TXN_LEN_1B = 2'd1;
   localparam logic [1:0] TXN_LEN_2B = 2'd2;

   // Largest of three cycle counts, used to size the shared timer
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/poll_timer.sv
// Loadable up-counter with enable, saturation at all-ones and a
// terminal compare (done when count has reached or passed term).
module poll_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         done
);

   logic [W-1:0] count;

   // Count up while enabled; a load wins over counting; never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   // ">=" so a period that elapsed while busy elsewhere still fires at once
   assign done = (count >= term);

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Transaction scheduler in front of the byte-level I2C master: checks the
// sensor ID once after boot, then polls the temperature register
// periodically, with NACK retries and a sticky fault.
module i2c_poll_scheduler
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
   parameter logic [7:0] ID_REG     = DEF_ID_REG,
   parameter logic [7:0] TEMP_REG   = DEF_TEMP_REG,
   parameter logic [7:0] EXP_ID     = DEF_EXP_ID,
   parameter int         BOOT_DELAY = 1000,
   parameter int         PERIOD     = 1_000_000,
   parameter int         RETRY_GAP  = 1000,
   parameter int         MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        poll_en,
   output logic        txn_valid,
   input  logic        txn_ready,
   output logic [7:0]  txn_sub_addr,
   output logic [6:0]  txn_dev_addr,
   output logic [1:0]  txn_len,
   input  logic        rsp_valid,
   input  logic        rsp_nack,
   input  logic [15:0] rsp_data,
   output logic [7:0]  id,
   output logic        id_ok,
   output logic [15:0] temp,
   output logic        temp_valid,
   output logic        err
);

   localparam int TW = $clog2(max3(BOOT_DELAY, PERIOD, RETRY_GAP)) + 1;
   localparam int RW = $clog2(MAX_RETRY + 2);

   localparam logic [TW-1:0] BOOT_TERM   = TW'(BOOT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_TERM = TW'(PERIOD - 1);
   localparam logic [TW-1:0] RETRY_TERM  = TW'(RETRY_GAP - 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   state_t          state, state_next;
   state_t          retry_target;
   logic [RW-1:0]   retry_cnt;
   logic            first_poll;

   logic            tmr_load;
   logic [TW-1:0]   tmr_load_val;
   logic            tmr_en;
   logic [TW-1:0]   tmr_term;
   logic            tmr_done;

   logic            in_wait;
   logic            ack_evt;
   logic            nack_evt;
   logic            capture_id;
   logic            capture_temp;
   logic            t_hs;

   // Responses only count while a transaction is outstanding
   assign in_wait  = (state == ST_ID_WAIT) || (state == ST_T_WAIT);
   assign ack_evt  = in_wait && rsp_valid && !rsp_nack;
   assign nack_evt = in_wait && rsp_valid && rsp_nack;
   assign t_hs     = (state == ST_T_REQ) && txn_valid && txn_ready;

   poll_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .term     (tmr_term),
      .done     (tmr_done)
   );

   // Terminal count depends only on which interval is being timed
   always_comb begin
      tmr_term = PERIOD_TERM;
      case (state)
         ST_BOOT:  tmr_term = BOOT_TERM;
         ST_RETRY: tmr_term = RETRY_TERM;
         default:  tmr_term = PERIOD_TERM;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and timer control. The cycle that starts an interval
   // (handshake or NACK) counts as its cycle 0, so the timer is loaded
   // with 1 there and intervals come out exactly PERIOD / RETRY_GAP long.
   always_comb begin
      state_next   = state;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_en       = 1'b0;
      capture_id   = 1'b0;
      capture_temp = 1'b0;
      case (state)
         ST_BOOT: begin
            tmr_en = 1'b1;
            if (tmr_done) state_next = ST_ID_REQ;
         end
         ST_ID_REQ: begin
            if (txn_valid && txn_ready) state_next = ST_ID_WAIT;
         end
         ST_ID_WAIT: begin
            if (nack_evt) begin
               if (retry_cnt == RETRY_LIMIT) begin
                  state_next = ST_FAULT;
               end else begin
                  state_next   = ST_RETRY;
                  tmr_load     = 1'b1;
                  tmr_load_val = TW'(1);
               end
            end else if (ack_evt) begin
               capture_id = 1'b1;
               if (rsp_data[7:0] == EXP_ID) begin
                  state_next   = ST_WAIT_PERIOD;
                  tmr_load     = 1'b1;
                  tmr_load_val = '0;
               end else begin
                  state_next = ST_FAULT;
               end
            end
         end
         ST_WAIT_PERIOD: begin
            tmr_en = poll_en;
            if (poll_en && (first_poll || tmr_done)) state_next = ST_T_REQ;
         end
         ST_T_REQ: begin
            tmr_en = 1'b1;
            if (t_hs) begin
               state_next   = ST_T_WAIT;
               tmr_load     = 1'b1;
               tmr_load_val = TW'(1);
            end
         end
         ST_T_WAIT: begin
            tmr_en = 1'b1;
            if (nack_evt) begin
               if (retry_cnt == RETRY_LIMIT) begin
                  state_next = ST_FAULT;
               end else begin
                  state_next   = ST_RETRY;
                  tmr_load     = 1'b1;
                  tmr_load_val = TW'(1);
               end
            end else if (ack_evt) begin
               capture_temp = 1'b1;
               state_next   = ST_WAIT_PERIOD;
            end
         end
         ST_RETRY: begin
            tmr_en = 1'b1;
            if (tmr_done) state_next = retry_target;
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_FAULT;
         end
      endcase
   end

   // Retry bookkeeping: consecutive NACK count, return target, first-poll flag
   always_ff @(posedge clk) begin
      if (reset) begin
         retry_cnt    <= '0;
         retry_target <= ST_ID_REQ;
         first_poll   <= 1'b0;
      end else begin
         if (ack_evt) begin
            retry_cnt <= '0;
         end else if (nack_evt && (retry_cnt != RETRY_LIMIT)) begin
            retry_cnt <= retry_cnt + RW'(1);
         end
         if (nack_evt) begin
            retry_target <= (state == ST_ID_WAIT) ? ST_ID_REQ : ST_T_REQ;
         end
         if (capture_id && (rsp_data[7:0] == EXP_ID)) begin
            first_poll <= 1'b1;
         end else if (t_hs) begin
            first_poll <= 1'b0;
         end
      end
   end

   // Registered request fields and published results
   always_ff @(posedge clk) begin
      if (reset) begin
         txn_valid    <= 1'b0;
         txn_sub_addr <= '0;
         txn_dev_addr <= '0;
         txn_len      <= '0;
         id           <= '0;
         id_ok        <= 1'b0;
         temp         <= '0;
         temp_valid   <= 1'b0;
         err          <= 1'b0;
      end else begin
         txn_valid    <= (state_next == ST_ID_REQ) || (state_next == ST_T_REQ);
         txn_dev_addr <= DEV_ADDR;
         if ((state_next == ST_ID_REQ) && (state != ST_ID_REQ)) begin
            txn_sub_addr <= ID_REG;
            txn_len      <= TXN_LEN_1B;
         end else if ((state_next == ST_T_REQ) && (state != ST_T_REQ)) begin
            txn_sub_addr <= TEMP_REG;
            txn_len      <= TXN_LEN_2B;
         end
         if (capture_id) begin
            id <= rsp_data[7:0];
            if (rsp_data[7:0] == EXP_ID) id_ok <= 1'b1;
         end
         temp_valid <= capture_temp;
         if (capture_temp) temp <= rsp_data;
         if (state_next == ST_FAULT) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Directed bench for i2c_poll_scheduler: a table of master transactions
// with hand-computed timing and results, plus hand-written sequences for
// poll_en pause, reset mid-transaction and the fault paths.
module tb_i2c_poll_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        poll_en = 1'b1;
   logic        txn_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic        rsp_nack = 1'b0;
   logic [15:0] rsp_data = '0;
   logic        txn_valid;
   logic [7:0]  txn_sub_addr;
   logic [6:0]  txn_dev_addr;
   logic [1:0]  txn_len;
   logic [7:0]  id;
   logic        id_ok;
   logic [15:0] temp;
   logic        temp_valid;
   logic        err;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int last_hs = 0;
   int last_ev = 0;

   typedef struct {
      logic [7:0]  sub;
      logic [1:0]  len;
      bit          ref_hs;    // gap measured from last handshake (1) or last response/reset release (0)
      int          gap;
      int          rdy_wait;
      int          rsp_lat;   // -1: no response
      bit          nack;
      logic [15:0] data;
      bit          exp_err;
   } vec_t;

   vec_t vecs[8];

   i2c_poll_scheduler #(
      .BOOT_DELAY (4),
      .PERIOD     (50),
      .RETRY_GAP  (5),
      .MAX_RETRY  (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .poll_en      (poll_en),
      .txn_valid    (txn_valid),
      .txn_ready    (txn_ready),
      .txn_sub_addr (txn_sub_addr),
      .txn_dev_addr (txn_dev_addr),
      .txn_len      (txn_len),
      .rsp_valid    (rsp_valid),
      .rsp_nack     (rsp_nack),
      .rsp_data     (rsp_data),
      .id           (id),
      .id_ok        (id_ok),
      .temp         (temp),
      .temp_valid   (temp_valid),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Act as the master for one transaction, checking request timing and fields
   task automatic run_txn(input vec_t v);
      int k;
      int stable_bad;
      logic [7:0] s;
      logic [1:0] l;
      k = 0;
      while (!txn_valid && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (!txn_valid) begin
         chk("req_timeout", 64'd0, 64'd1);
         return;
      end
      chk("req_gap", 64'(cyc - (v.ref_hs ? last_hs : last_ev)), 64'(v.gap));
      chk("req_sub", 64'(txn_sub_addr), 64'(v.sub));
      chk("req_len", 64'(txn_len), 64'(v.len));
      chk("req_dev", 64'(txn_dev_addr), 64'h4B);
      s = txn_sub_addr;
      l = txn_len;
      stable_bad = 0;
      for (int i = 0; i < v.rdy_wait; i++) begin
         @(negedge clk);
         if (!txn_valid || txn_sub_addr !== s || txn_len !== l) stable_bad++;
      end
      if (v.rdy_wait > 0) chk("req_stable", 64'(stable_bad), 64'd0);
      txn_ready = 1'b1;
      last_hs = cyc;
      @(negedge clk);
      txn_ready = 1'b0;
      chk("valid_drop", 64'(txn_valid), 64'd0);
      if (v.rsp_lat < 0) return;
      repeat (v.rsp_lat) @(negedge clk);
      rsp_valid = 1'b1;
      rsp_nack  = v.nack;
      rsp_data  = v.data;
      last_ev   = cyc;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      chk("err", 64'(err), 64'(v.exp_err));
      if (!v.nack) begin
         chk("retry_clr", 64'(dut.retry_cnt), 64'd0);
         if (v.sub == 8'h0B) begin
            chk("id", 64'(id), 64'(v.data[7:0]));
            chk("id_ok", 64'(id_ok), 64'(v.data[7:0] == 8'hCB));
         end else begin
            chk("temp", 64'(temp), 64'(v.data));
            chk("temp_valid", 64'(temp_valid), 64'd1);
         end
      end else begin
         chk("nack_no_tv", 64'(temp_valid), 64'd0);
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk(nm, {txn_valid, txn_sub_addr, txn_dev_addr, txn_len, id, id_ok, temp, temp_valid, err}, 64'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      chk_reset_outs("reset_outs");
      reset = 1'b0;
      last_ev = cyc;
   endtask

   initial begin
      int cnt;
      vec_t v;
      //            sub    len ref gap  rdy lat nack data      err
      vecs[0] = '{8'h0B, 2'd1, 0,   4,   0,  3, 0, 16'h00CB, 0};  // boot ID read
      vecs[1] = '{8'h00, 2'd2, 0,   2,   0,  5, 0, 16'h0C80, 0};  // immediate first poll
      vecs[2] = '{8'h00, 2'd2, 1,  50,   0,  5, 0, 16'h0D00, 0};  // periodic
      vecs[3] = '{8'h00, 2'd2, 1,  50,   0,  4, 1, 16'h0000, 0};  // NACK 1
      vecs[4] = '{8'h00, 2'd2, 0,   5,   0,  2, 1, 16'h0000, 0};  // NACK 2
      vecs[5] = '{8'h00, 2'd2, 0,   5,   0,  3, 0, 16'h0E10, 0};  // recovered
      vecs[6] = '{8'h00, 2'd2, 1,  50,  10,  4, 0, 16'h0F00, 0};  // backpressure
      vecs[7] = '{8'h00, 2'd2, 1,  50,   0,  3, 0, 16'h1234, 0};

      repeat (3) @(negedge clk);
      chk_reset_outs("reset_outs");
      reset = 1'b0;
      last_ev = cyc;

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // poll_en low for 100 cycles in WAIT_PERIOD, with a stray response
      poll_en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 40) begin
            rsp_valid = 1'b1;
            rsp_data  = 16'hFFFF;
         end
         if (i == 41) begin
            rsp_valid = 1'b0;
            chk("stray_tv", 64'(temp_valid), 64'd0);
            chk("stray_temp", 64'(temp), 64'h1234);
         end
         @(negedge clk);
         if (txn_valid) cnt++;
      end
      chk("paused_reqs", 64'(cnt), 64'd0);
      poll_en = 1'b1;
      v = '{8'h00, 2'd2, 1, 150, 0, 2, 0, 16'h1357, 0};
      run_txn(v);

      // Reset while waiting for a temperature response
      v = '{8'h00, 2'd2, 1, 50, 0, -1, 0, 16'h0000, 0};
      run_txn(v);
      pulse_reset();
      v = '{8'h0B, 2'd1, 0, 4, 0, 1, 0, 16'h00CB, 0};
      run_txn(v);

      // Three NACKs on the ID read fault with MAX_RETRY=2
      pulse_reset();
      v = '{8'h0B, 2'd1, 0, 4, 0, 2, 1, 16'h0000, 0};
      run_txn(v);
      v = '{8'h0B, 2'd1, 0, 5, 0, 2, 1, 16'h0000, 0};
      run_txn(v);
      v = '{8'h0B, 2'd1, 0, 5, 0, 2, 1, 16'h0000, 1};
      run_txn(v);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (txn_valid) cnt++;
      end
      chk("fault_no_req", 64'(cnt), 64'd0);
      chk("fault_err_sticky", 64'(err), 64'd1);

      // Wrong ID value faults without setting id_ok
      pulse_reset();
      v = '{8'h0B, 2'd1, 0, 4, 0, 1, 0, 16'h0000, 1};
      run_txn(v);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (txn_valid) cnt++;
      end
      chk("badid_no_req", 64'(cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
